// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and frame sizing.
package uart_pkg;

    typedef enum logic [1:0] {
        ParityNone = 2'd0,
        ParityOdd  = 2'd1,
        ParityEven = 2'd2
    } uart_parity_e;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } uart_tx_state_e;

    function automatic int unsigned uart_frame_bits(input int unsigned data_bits,
                                                    input int unsigned parity,
                                                    input int unsigned stop_bits);
        return 1 + data_bits + ((parity != 0) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a combinational head read and a registered occupancy count.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q, level_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok, pop_ok;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign level   = level_q;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            if (push_ok && !pop_ok) begin
                level_q <= level_q + (AW+1)'(1);
            end else if (!push_ok && pop_ok) begin
                level_q <= level_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered UART transmitter: FIFO-fed serializer with optional parity and 1-2 stop bits.
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_DIV  = 434,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              txValid,
    input  logic [DATA_BITS-1:0]              txData,
    output logic                              txReady,
    output logic                              uartTx,
    output logic                              uartBusyTx,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifoLevel
);

    localparam int unsigned  CntW       = $clog2(CLOCK_DIV);
    localparam int unsigned  BitW       = 4;
    localparam uart_parity_e ParityMode = uart_parity_e'(2'(PARITY));

    uart_tx_state_e       state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 parity_q, parity_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;

    logic [DATA_BITS-1:0] head;
    logic                 full, empty, pop, load, bit_end, head_parity;

    uart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (txValid),
        .push_data (txData),
        .pop       (pop),
        .rd_data   (head),
        .full      (full),
        .empty     (empty),
        .level     (fifoLevel)
    );

    assign txReady     = !full;
    assign uartTx      = tx_q;
    assign uartBusyTx  = busy_q;
    assign bit_end     = (cnt_q == CntW'(CLOCK_DIV - 1));
    assign head_parity = (ParityMode == ParityOdd) ? ~^head : ^head;

    always_comb begin
        state_d  = state_q;
        cnt_d    = bit_end ? '0 : cnt_q + CntW'(1);
        bit_d    = bit_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;
        load     = 1'b0;
        pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!empty) load = 1'b1;
            end
            StStart: begin
                if (bit_end) begin
                    state_d = StData;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end
            end
            StData: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == BitW'(DATA_BITS - 1)) begin
                        bit_d = '0;
                        if (ParityMode != ParityNone) begin
                            state_d = StParity;
                            tx_d    = parity_q;
                        end else begin
                            state_d = StStop;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + BitW'(1);
                        tx_d  = shift_q[1];
                    end
                end
            end
            StParity: begin
                if (bit_end) begin
                    state_d = StStop;
                    bit_d   = '0;
                    tx_d    = 1'b1;
                end
            end
            StStop: begin
                if (bit_end) begin
                    if (bit_q == BitW'(STOP_BITS - 1)) begin
                        // Back-to-back frames: reload on the very edge the stop bit ends.
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = StIdle;
                            tx_d    = 1'b1;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_d = bit_q + BitW'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load) begin
            pop      = 1'b1;
            shift_d  = head;
            parity_d = head_parity;
            cnt_d    = '0;
            bit_d    = '0;
            tx_d     = 1'b0;
            busy_d   = 1'b1;
            state_d  = StStart;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            parity_q <= 1'b0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

endmodule

// File: doc/uart_tx_buffered.md
# uart_tx_buffered

Parametrised, buffered UART transmitter that supersedes the single-word transmitter. It adds configurable data width, optional odd/even parity, 1 or 2 stop bits and an internal transmit FIFO with a valid/ready write port, so the producer can queue several bytes at once. Frames from the FIFO are sent back-to-back with no idle gap. The block sits between the SoC bus/peripheral register logic and the `uartTx` pad.

## Interface
- CLOCK_DIV, 434, clocks per bit period; legal range ≥2.
- DATA_BITS, 8, data bits per frame; legal range 5–9.
- PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits per frame; legal values 1 or 2.
- FIFO_DEPTH, 4, transmit FIFO entries; must be a power of two, ≥2.

- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- txValid  in  1  write request for `txData`.
- txData  in  DATA_BITS  word to queue.
- txReady  out  1  FIFO can accept a word; equals `!full`.
- uartTx  out  1  serial line; idle high.
- uartBusyTx  out  1  high while a frame is on the line.
- fifoLevel  out  $clog2(FIFO_DEPTH+1)  number of queued words, excluding the one being shifted.

## Operation
- **Write handshake**
  - A word is written when `txValid && txReady` at a rising edge.
  - `txReady` is combinational `!full`.
  - A write while full is not accepted; `txData` is ignored and the producer must hold it.
- **Frame format, in order**
  - Start bit (0).
  - DATA_BITS data bits, LSB first.
  - Parity bit, if PARITY≠0. Even parity: `^data`. Odd parity: `~^data`.
  - STOP_BITS stop bits (1).
- **Serializer FSM states**: IDLE, START, DATA, PARITY, STOP.
  - IDLE → START when FIFO is non-empty. On that edge: pop the head into the shift register, drive `uartTx`=0, and set `uartBusyTx`=1.
  - START → DATA after CLOCK_DIV cycles.
  - DATA → PARITY (or STOP when PARITY=0) after DATA_BITS bit periods. The shift register shifts right once per bit period.
  - PARITY → STOP after 1 bit period.
  - At the end of the last stop bit:
    - FIFO non-empty → pop and go directly to START on the same edge; `uartBusyTx` stays 1 (zero-gap streaming).
    - FIFO empty → go to IDLE, `uartTx`=1, `uartBusyTx`=0.
- **Baud counter**
  - Counts 0..CLOCK_DIV-1.
  - Restarted to 0 on every frame load.
  - Wraps to 0 at each bit boundary.
- **Outputs are registered**: `uartTx`, `uartBusyTx`, `fifoLevel`.
- **Simultaneous write and pop** on the same edge: `fifoLevel` is unchanged.
- **Reset values**: `uartTx`=1, `uartBusyTx`=0, `fifoLevel`=0, `txReady`=1, FSM=IDLE, FIFO pointers 0.
- **Reset behaviour**
  - Writes presented while `rst`=1 are discarded.
  - Reset mid-frame truncates the frame: `uartTx`=1 on the next edge and all queued words are flushed.

## Timing
- Frame length: CLOCK_DIV × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
  - Default parameters: 4340 cycles.
- Write at edge E while IDLE and the FIFO is empty:
  - `fifoLevel`=1 after E.
  - Pop at E+1: `uartTx`=0, `uartBusyTx`=1, `fifoLevel`=0 after E+1.
- `uartTx` changes only at bit boundaries, i.e. every CLOCK_DIV cycles after the load edge.
- `uartBusyTx` falls on the same edge the last stop bit ends.
- Streaming: the stop-bit-to-start-bit transition of consecutive frames occurs on one edge, with no idle cycles.
- A word written during the final cycle of a stop bit is visible one edge later. If the FIFO was empty at the boundary, one IDLE cycle is inserted.

## Structure
- Package `uart_pkg`:
  - `uart_parity_e` (NONE/ODD/EVEN).
  - `uart_tx_state_e`.
  - Function `uart_frame_bits(DATA_BITS, PARITY, STOP_BITS)`.
  - Shared with the future receiver.
- Sub-module `uart_sync_fifo` (parameters WIDTH, DEPTH):
  - Write port and pop port.
  - Outputs: `full`, `empty`, `level`.
  - Read data valid combinationally from the head.
  - Pointer wrap by natural overflow of $clog2(DEPTH)+1-bit pointers.
- Top level holds the FSM, baud counter, bit counter and shift register.

## Test plan
- Single byte, defaults, write 8'hA5:
  - `uartTx` = 0,1,0,1,0,0,1,0,1,1, each bit held 434 cycles.
  - `uartBusyTx` high for exactly 4340 cycles.
- Even parity, DATA_BITS=8, write 8'h07: parity bit = 1. Odd parity, write 8'h07: parity bit = 0. Frame length 4774 cycles.
- STOP_BITS=2, DATA_BITS=7, CLOCK_DIV=16, write 7'h55:
  - Frame length 160 cycles.
  - Line high for the last 32 cycles.
- FIFO_DEPTH=4, CLOCK_DIV=4, write 6 words back-to-back with `txValid` held:
  - 5 words accepted: 1 loaded into the shifter, then 4 queued.
  - `txReady`=0 until the next pop.
  - All 6 frames transmitted contiguously.
  - `uartBusyTx` never drops between frames.
  - `fifoLevel` peaks at 4.
- Assert `rst` for 1 cycle mid-DATA with 3 words queued:
  - `uartTx`=1, `uartBusyTx`=0, `fifoLevel`=0 on the next edge.
  - No further frames transmitted.
- Write with `txValid`=1 while `rst`=1: no frame transmitted after reset release.
